// File: rtl/dram_arb_pkg.sv
// Shared types and widths for the stereo camera DRAM write arbiter.
package dram_arb_pkg;

    localparam int unsigned DATA_WIDTH         = 128;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 27;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wr_addr_gen.sv
// Per-port frame address generator: word counter with tlast reset and wrap,
// sticky overflow flag, frame-done pulse and (with PINGPONG_EN) bank toggle.
// Optional feature macro: PINGPONG_EN.
module wr_addr_gen
    import dram_arb_pkg::*;
#(
    parameter int unsigned NUM_ADDRESSES = 3600,
    parameter int unsigned BASE_ADDR     = 0,
    parameter int unsigned ADDR_WIDTH    = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  hs,
    input  logic                  tlast,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  overflow,
    output logic                  frame_done,
    output logic                  front_bank
);

    localparam int unsigned CNT_W = (NUM_ADDRESSES > 1) ? $clog2(NUM_ADDRESSES) : 1;

    logic [CNT_W-1:0] addr_cnt;
    logic             bank;
    logic             at_end_c;

    assign at_end_c = (addr_cnt == CNT_W'(NUM_ADDRESSES - 1));

    // Word counter, overflow flag and frame-done pulse
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_cnt   <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= hs && tlast;
            if (hs) begin
                if (tlast || at_end_c) begin
                    addr_cnt <= '0;
                end else begin
                    addr_cnt <= addr_cnt + CNT_W'(1);
                end
                if (at_end_c && !tlast) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

`ifdef PINGPONG_EN
    // Alternate between two frame regions; report the bank just finished
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bank       <= 1'b0;
            front_bank <= 1'b0;
        end else if (hs && tlast) begin
            bank       <= ~bank;
            front_bank <= bank;
        end
    end
`else
    assign bank       = 1'b0;
    assign front_bank = 1'b0;
`endif

    // Full word address of the beat currently presented
    assign addr = ADDR_WIDTH'(BASE_ADDR)
                + (bank ? ADDR_WIDTH'(NUM_ADDRESSES) : ADDR_WIDTH'(0))
                + ADDR_WIDTH'(addr_cnt);

endmodule

// File: rtl/dram_write_arbiter.sv
// Two-port round-robin burst arbiter merging left/right camera write streams
// onto one DRAM address+data stream. Zero-latency data path once granted.
// Optional feature macro: PINGPONG_EN (double-buffered frame regions).
module dram_write_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned NUM_ADDRESSES = 3600,
    parameter int unsigned BASE_ADDR_0   = 0,
    parameter int unsigned BASE_ADDR_1   = 8192,
    parameter int unsigned BURST_LEN     = 8,
    parameter int unsigned ADDR_WIDTH    = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [DATA_WIDTH-1:0] s0_axis_data,
    input  logic                  s0_axis_valid,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_ready,
    input  logic [DATA_WIDTH-1:0] s1_axis_data,
    input  logic                  s1_axis_valid,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_ready,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic [ADDR_WIDTH-1:0] m_axis_addr,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic [1:0]            frame_done_out,
    output logic [1:0]            overflow_out,
    output logic [1:0]            front_bank_out
);

    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    arb_state_t        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic                  hs_c, hs0_c, hs1_c;
    logic                  grant_port_c, grant_valid_c, grant_last_c, other_valid_c;
    logic                  release_c;
    logic [ADDR_WIDTH-1:0] addr0, addr1;

    assign hs_c          = m_axis_valid && m_axis_ready;
    assign hs0_c         = hs_c && (state_q == ARB_GRANT0);
    assign hs1_c         = hs_c && (state_q == ARB_GRANT1);
    assign grant_port_c  = (state_q == ARB_GRANT1);
    assign grant_valid_c = grant_port_c ? s1_axis_valid : s0_axis_valid;
    assign grant_last_c  = grant_port_c ? s1_axis_tlast : s0_axis_tlast;
    assign other_valid_c = grant_port_c ? s0_axis_valid : s1_axis_valid;
    assign release_c     = (hs_c && (grant_last_c || (beat_cnt_q == BEAT_W'(BURST_LEN - 1))))
                         || !grant_valid_c;

    // Arbiter state, round-robin pointer and burst beat counter
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // Next-state: round-robin grant with bounded bursts
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (s0_axis_valid && s1_axis_valid) begin
                    state_d = last_grant_q ? ARB_GRANT0 : ARB_GRANT1;
                end else if (s0_axis_valid) begin
                    state_d = ARB_GRANT0;
                end else if (s1_axis_valid) begin
                    state_d = ARB_GRANT1;
                end
            end
            ARB_GRANT0, ARB_GRANT1: begin
                if (release_c) begin
                    beat_cnt_d   = '0;
                    last_grant_d = grant_port_c;
                    if (other_valid_c) begin
                        state_d = grant_port_c ? ARB_GRANT0 : ARB_GRANT1;
                    end else if (grant_valid_c) begin
                        state_d = state_q;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (hs_c) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Zero-latency mux of the granted port onto the merged stream
    always_comb begin
        m_axis_valid  = 1'b0;
        m_axis_data   = '0;
        m_axis_addr   = '0;
        s0_axis_ready = 1'b0;
        s1_axis_ready = 1'b0;
        case (state_q)
            ARB_GRANT0: begin
                m_axis_valid  = s0_axis_valid;
                m_axis_data   = s0_axis_data;
                m_axis_addr   = addr0;
                s0_axis_ready = m_axis_ready;
            end
            ARB_GRANT1: begin
                m_axis_valid  = s1_axis_valid;
                m_axis_data   = s1_axis_data;
                m_axis_addr   = addr1;
                s1_axis_ready = m_axis_ready;
            end
            default: ;
        endcase
    end

    wr_addr_gen #(
        .NUM_ADDRESSES (NUM_ADDRESSES),
        .BASE_ADDR     (BASE_ADDR_0),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) u_addr_gen0 (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .hs         (hs0_c),
        .tlast      (s0_axis_tlast),
        .addr       (addr0),
        .overflow   (overflow_out[0]),
        .frame_done (frame_done_out[0]),
        .front_bank (front_bank_out[0])
    );

    wr_addr_gen #(
        .NUM_ADDRESSES (NUM_ADDRESSES),
        .BASE_ADDR     (BASE_ADDR_1),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) u_addr_gen1 (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .hs         (hs1_c),
        .tlast      (s1_axis_tlast),
        .addr       (addr1),
        .overflow   (overflow_out[1]),
        .frame_done (frame_done_out[1]),
        .front_bank (front_bank_out[1])
    );

endmodule

// File: tb/tb_dram_write_arbiter.sv
// Directed self-checking bench for dram_write_arbiter.
module tb_dram_write_arbiter;
    import dram_arb_pkg::*;

    localparam int NUM = 3600;
    localparam int B0  = 0;
    localparam int B1  = 8192;
    localparam int AW  = 27;

    logic                  clk_in = 1'b0;
    logic                  rst_n_in;
    logic [DATA_WIDTH-1:0] s0_axis_data, s1_axis_data, m_axis_data;
    logic                  s0_axis_valid, s0_axis_tlast, s0_axis_ready;
    logic                  s1_axis_valid, s1_axis_tlast, s1_axis_ready;
    logic [AW-1:0]         m_axis_addr;
    logic                  m_axis_valid, m_axis_ready;
    logic [1:0]            frame_done_out, overflow_out, front_bank_out;

    int n_checks = 0;
    int n_pass   = 0;
    int k, c0, c1, cyc, idx, exp_p, exp_addr;
    logic [127:0] exp_data;

    always #5 clk_in = ~clk_in;

    dram_write_arbiter dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .s0_axis_data   (s0_axis_data),
        .s0_axis_valid  (s0_axis_valid),
        .s0_axis_tlast  (s0_axis_tlast),
        .s0_axis_ready  (s0_axis_ready),
        .s1_axis_data   (s1_axis_data),
        .s1_axis_valid  (s1_axis_valid),
        .s1_axis_tlast  (s1_axis_tlast),
        .s1_axis_ready  (s1_axis_ready),
        .m_axis_data    (m_axis_data),
        .m_axis_addr    (m_axis_addr),
        .m_axis_valid   (m_axis_valid),
        .m_axis_ready   (m_axis_ready),
        .frame_done_out (frame_done_out),
        .overflow_out   (overflow_out),
        .front_bank_out (front_bank_out)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input int p, input logic v, input logic [127:0] d, input logic l);
        if (p == 0) begin
            s0_axis_valid = v; s0_axis_data = d; s0_axis_tlast = l;
        end else begin
            s1_axis_valid = v; s1_axis_data = d; s1_axis_tlast = l;
        end
    endtask

    function automatic logic port_ready(input int p);
        return (p == 0) ? s0_axis_ready : s1_axis_ready;
    endfunction

    task automatic apply_reset();
        @(negedge clk_in);
        rst_n_in = 1'b0;
        drive(0, 1'b0, 128'(0), 1'b0);
        drive(1, 1'b0, 128'(0), 1'b0);
        m_axis_ready = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    // Send n beats on port p; beat i expected at base + off + (i mod NUM)
    task automatic stream(input int p, input int n, input bit last, input int off, input string tag);
        int i = 0;
        int cc = 0;
        int base = (p == 0) ? B0 : B1;
        m_axis_ready = 1'b1;
        @(negedge clk_in);
        while (i < n && cc < n + 64) begin
            drive(p, 1'b1, 128'(i) | (128'(p) << 120), last && (i == n - 1));
            #1;
            if (m_axis_valid && m_axis_ready && port_ready(p)) begin
                check({tag, "_addr"}, 128'(m_axis_addr), 128'(base + off + (i % NUM)));
                i++;
            end
            @(negedge clk_in);
            cc++;
        end
        drive(p, 1'b0, 128'(0), 1'b0);
        if (i < n) check({tag, "_timeout"}, 128'(i), 128'(n));
    endtask

    initial begin
        rst_n_in = 1'b0;
        drive(0, 1'b0, 128'(0), 1'b0);
        drive(1, 1'b0, 128'(0), 1'b0);
        m_axis_ready = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        #1;
        check("rst_m_valid",    128'(m_axis_valid),   128'(0));
        check("rst_s0_ready",   128'(s0_axis_ready),  128'(0));
        check("rst_s1_ready",   128'(s1_axis_ready),  128'(0));
        check("rst_frame_done", 128'(frame_done_out), 128'(0));
        check("rst_overflow",   128'(overflow_out),   128'(0));
        check("rst_front_bank", 128'(front_bank_out), 128'(0));
        check("rst_m_addr",     128'(m_axis_addr),    128'(0));
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Full frame on port 0
        m_axis_ready = 1'b1;
        @(negedge clk_in);
        drive(0, 1'b1, 128'(0), 1'b0);
        #1;
        check("t1_idle_no_valid", 128'(m_axis_valid), 128'(0));
        stream(0, NUM, 1'b1, 0, "t1");
        #1;
        check("t1_frame_done", 128'(frame_done_out), 128'h1);
        check("t1_overflow",   128'(overflow_out),   128'h0);
        check("t1_front_bank", 128'(front_bank_out), 128'h0);
        @(negedge clk_in);
        #1;
        check("t1_done_single", 128'(frame_done_out), 128'h0);

        // Both ports continuously valid: 8/8 alternation
        apply_reset();
        c0 = 0; c1 = 0; k = 0; cyc = 0;
        while (k < 32 && cyc < 100) begin
            @(negedge clk_in);
            drive(0, 1'b1, 128'h1000 | 128'(c0), 1'b0);
            drive(1, 1'b1, 128'h2000 | 128'(c1), 1'b0);
            #1;
            if (m_axis_valid && m_axis_ready) begin
                exp_p    = (k / 8) % 2;
                exp_addr = (exp_p == 1 ? B1 : B0) + 8 * (k / 16) + (k % 8);
                exp_data = (exp_p == 1) ? (128'h2000 | 128'(c1)) : (128'h1000 | 128'(c0));
                check("t2_port", 128'(s1_axis_ready), 128'(exp_p));
                check("t2_addr", 128'(m_axis_addr), 128'(exp_addr));
                check("t2_data", m_axis_data, exp_data);
                if (s1_axis_ready) c1++; else c0++;
                k++;
            end
            cyc++;
        end
        if (k < 32) check("t2_timeout", 128'(k), 128'(32));

        // Port 1 stalled by downstream while port 0 requests
        apply_reset();
        m_axis_ready = 1'b0;
        @(negedge clk_in);
        drive(1, 1'b1, 128'h55, 1'b0);
        #1;
        check("t3_idle", 128'(m_axis_valid), 128'(0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            if (i == 0) drive(0, 1'b1, 128'h66, 1'b0);
            #1;
            check("t3_hold_valid", 128'(m_axis_valid), 128'(1));
            check("t3_hold_data",  m_axis_data, 128'h55);
            check("t3_s0_ready",   128'(s0_axis_ready), 128'(0));
        end
        check("t3_hold_addr", 128'(m_axis_addr), 128'(B1));
        @(negedge clk_in);
        m_axis_ready  = 1'b1;
        s1_axis_tlast = 1'b1;
        #1;
        check("t3_accept_s1", 128'(s1_axis_ready), 128'(1));
        @(negedge clk_in);
        drive(1, 1'b0, 128'(0), 1'b0);
        m_axis_ready = 1'b0;
        #1;
        check("t3_switch_data", m_axis_data, 128'h66);
        check("t3_switch_addr", 128'(m_axis_addr), 128'(B0));
        check("t3_frame_done",  128'(frame_done_out), 128'h2);
        check("t3_no_overflow", 128'(overflow_out), 128'h0);
        @(negedge clk_in);
        drive(0, 1'b0, 128'(0), 1'b0);

        // Port 0 overruns the frame without tlast
        apply_reset();
        stream(0, NUM + 1, 1'b0, 0, "t4");
        #1;
        check("t4_overflow", 128'(overflow_out), 128'h1);
        stream(0, 4, 1'b1, 1, "t4b");
        #1;
        check("t4_sticky",     128'(overflow_out),   128'h1);
        check("t4_frame_done", 128'(frame_done_out), 128'h1);

        // Second frame placement
        apply_reset();
        stream(0, NUM, 1'b1, 0, "t5f0");
        #1;
        check("t5_done0",  128'(frame_done_out), 128'h1);
        check("t5_front0", 128'(front_bank_out), 128'h0);
`ifdef PINGPONG_EN
        stream(0, NUM, 1'b1, NUM, "t5f1");
        #1;
        check("t5_front1", 128'(front_bank_out), 128'h1);
`else
        stream(0, 4, 1'b1, 0, "t5f1");
        #1;
        check("t5_front1", 128'(front_bank_out), 128'h0);
`endif

        // Reset asserted mid-burst on port 1
        apply_reset();
        idx = 0; cyc = 0;
        while (idx < 4 && cyc < 20) begin
            @(negedge clk_in);
            drive(1, 1'b1, 128'(idx), 1'b0);
            #1;
            if (m_axis_valid && m_axis_ready && s1_axis_ready) idx++;
            cyc++;
        end
        check("t6_pre_beats", 128'(idx), 128'(4));
        @(negedge clk_in);
        drive(1, 1'b1, 128'(4), 1'b0);
        #1;
        check("t6_beat4_addr", 128'(m_axis_addr), 128'(B1 + 4));
        rst_n_in = 1'b0;
        #1;
        check("t6_rst_valid",    128'(m_axis_valid),  128'(0));
        check("t6_rst_s1_ready", 128'(s1_axis_ready), 128'(0));
        check("t6_rst_s0_ready", 128'(s0_axis_ready), 128'(0));
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        #1;
        check("t6_restart_ready", 128'(s1_axis_ready), 128'(1));
        check("t6_restart_addr",  128'(m_axis_addr),   128'(B1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
